// File: rtl/sb_regfile.sv
// Scoreboarded register file: two read ports, one writeback port and a
// per-register in-flight write counter that tracks issued producers.
module sb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_full,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              err_underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt  [DEPTH];
    logic              err_q;

    logic zero_rd_a, zero_rd_b, zero_iss, zero_wr;
    logic wb, iss_live, iss_ok;
    logic byp_a, byp_b;

    assign zero_rd_a = (ZERO_REG != 0) && (rd_addr_a == '0);
    assign zero_rd_b = (ZERO_REG != 0) && (rd_addr_b == '0);
    assign zero_iss  = (ZERO_REG != 0) && (iss_addr == '0);
    assign zero_wr   = (ZERO_REG != 0) && (wr_addr == '0);

    // Hardwired r0 traffic is invisible to both storage and scoreboard.
    assign wb       = wr_en && !zero_wr;
    assign iss_live = iss_en && !zero_iss;
    assign iss_full = iss_live && (cnt[iss_addr] == CNT_MAX);
    assign iss_ok   = iss_live && (cnt[iss_addr] != CNT_MAX);

    assign byp_a = (BYPASS != 0) && wb && (wr_addr == rd_addr_a);
    assign byp_b = (BYPASS != 0) && wb && (wr_addr == rd_addr_b);

    assign err_underflow = err_q;

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (byp_a) rd_data_a = wr_data;
        if (byp_b) rd_data_b = wr_data;
        if (zero_rd_a) rd_data_a = '0;
        if (zero_rd_b) rd_data_b = '0;
    end

    // A retiring last producer is not a hazard when its data is forwarded.
    always_comb begin
        rd_busy_a = (cnt[rd_addr_a] != '0);
        rd_busy_b = (cnt[rd_addr_b] != '0);
        if (byp_a && cnt[rd_addr_a] == CNT_ONE) rd_busy_a = 1'b0;
        if (byp_b && cnt[rd_addr_b] == CNT_ONE) rd_busy_b = 1'b0;
        if (zero_rd_a) rd_busy_a = 1'b0;
        if (zero_rd_b) rd_busy_b = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wb) regs[wr_addr] <= wr_data;
            if (wb && cnt[wr_addr] == '0) err_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (iss_ok && iss_addr == ADDR_W'(i)) begin
                    if (!(wb && wr_addr == ADDR_W'(i)))
                        cnt[i] <= cnt[i] + CNT_ONE;
                end else if (wb && wr_addr == ADDR_W'(i)) begin
                    if (cnt[i] != '0)
                        cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_regfile.sv
// Bench for sb_regfile: directed scenarios plus randomized traffic
// compared against an array-based scoreboard model.
module tb_sb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr_a, rd_addr_b, iss_addr, wr_addr;
    logic        iss_en, wr_en;
    logic [31:0] wr_data;

    logic [31:0] a_rda, a_rdb, b_rda, b_rdb;
    logic        a_bsa, a_bsb, b_bsa, b_bsb;
    logic        a_full, b_full, a_err, b_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;

    always #5 clk = ~clk;

    sb_regfile #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(a_rda), .rd_data_b(a_rdb),
        .rd_busy_a(a_bsa), .rd_busy_b(a_bsb),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(a_full),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_underflow(a_err)
    );

    sb_regfile #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(b_rda), .rd_data_b(b_rdb),
        .rd_busy_a(b_bsa), .rd_busy_b(b_bsb),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(b_full),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_underflow(b_err)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (byp && wr_en && wr_addr == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_full();
        return iss_en && iss_addr != 0 && m_cnt[iss_addr] == 3;
    endfunction

    task automatic model_tick();
        bit acc, wb;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'h0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
            return;
        end
        acc = iss_en && iss_addr != 0 && m_cnt[iss_addr] < 3;
        wb  = wr_en && wr_addr != 0;
        if (wb) begin
            if (m_cnt[wr_addr] == 0) m_err = 1'b1;
            m_reg[wr_addr] = wr_data;
        end
        if (!(acc && wb && iss_addr == wr_addr)) begin
            if (acc) m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
            if (wb && m_cnt[wr_addr] > 0) m_cnt[wr_addr] = m_cnt[wr_addr] - 1;
        end
    endtask

    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; iss_en = 1'b0; wr_en = 1'b0;
        iss_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'h0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] a);
        idle(); iss_en = 1'b1; iss_addr = a; cyc();
    endtask

    task automatic wback(input logic [4:0] a, input logic [31:0] d);
        idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; cyc();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hDEADBEEF;
        cyc();
        #1;
        checks++;
        if (a_rda !== 32'h0 || a_bsa !== 1'b0 || a_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs got data=%h busy=%b full=%b want 0/0/0",
                     a_rda, a_bsa, a_full);
        end
        idle();
        rd_addr_a = 5'd6;
        #1;
        checks++;
        if (a_rda !== 32'h0 || a_bsa !== 1'b0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_r6 got data=%h busy=%b err=%b want 0/0/0",
                     a_rda, a_bsa, a_err);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        wback(5'd5, 32'h12345678);
        idle(); rd_addr_a = 5'd5;
        #1;
        checks++;
        if (a_rda !== 32'h12345678 || a_bsa !== 1'b0) begin
            failures++;
            $display("FAIL write_read got data=%h busy=%b want 12345678/0",
                     a_rda, a_bsa);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        wback(5'd0, 32'hFFFFFFFF);
        idle(); iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        checks++;
        if (a_rda !== 32'h0 || a_full !== 1'b0 || a_bsa !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg got data=%h full=%b busy=%b want 0/0/0",
                     a_rda, a_full, a_bsa);
        end
        cyc();
        issue(5'd0); issue(5'd0); issue(5'd0);
        idle(); iss_en = 1'b1;
        #1;
        checks++;
        if (a_full !== 1'b0 || a_bsa !== 1'b0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_cnt got full=%b busy=%b err=%b want 0/0/0",
                     a_full, a_bsa, a_err);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        issue(5'd7); issue(5'd7);
        wback(5'd7, 32'h11110000);
        idle(); rd_addr_a = 5'd7;
        #1;
        checks++;
        if (a_bsa !== 1'b1 || a_rda !== 32'h11110000) begin
            failures++;
            $display("FAIL pend_r7 got busy=%b data=%h want 1/11110000",
                     a_bsa, a_rda);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        #1;
        checks++;
        if (a_rda !== 32'hA5A5A5A5 || a_bsa !== 1'b0) begin
            failures++;
            $display("FAIL bypass_on got data=%h busy=%b want a5a5a5a5/0",
                     a_rda, a_bsa);
        end
        checks++;
        if (b_rda !== 32'h11110000 || b_bsa !== 1'b1) begin
            failures++;
            $display("FAIL bypass_off got data=%h busy=%b want 11110000/1",
                     b_rda, b_bsa);
        end
        cyc();
        idle(); rd_addr_a = 5'd7;
        #1;
        checks++;
        if (b_rda !== 32'hA5A5A5A5 || b_bsa !== 1'b0) begin
            failures++;
            $display("FAIL nobyp_next got data=%h busy=%b want a5a5a5a5/0",
                     b_rda, b_bsa);
        end
    endtask

    task automatic test_full();
        do_reset();
        issue(5'd3); issue(5'd3); issue(5'd3);
        idle(); iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        checks++;
        if (a_full !== 1'b1) begin
            failures++;
            $display("FAIL full_r3 got %b want 1", a_full);
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            wback(5'd3, 32'h300 + k);
            idle(); rd_addr_a = 5'd3;
            #1;
            checks++;
            if (a_bsa !== (k < 2)) begin
                failures++;
                $display("FAIL drain_r3_%0d got busy=%b want %b", k, a_bsa, k < 2);
            end
        end
        checks++;
        if (a_err !== 1'b0) begin
            failures++;
            $display("FAIL full_err got %b want 0 (refused issue counted)", a_err);
        end
    endtask

    task automatic test_simul();
        do_reset();
        issue(5'd9);
        idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        cyc();
        idle(); rd_addr_a = 5'd9;
        #1;
        checks++;
        if (a_bsa !== 1'b1 || a_rda !== 32'h99) begin
            failures++;
            $display("FAIL simul_r9 got busy=%b data=%h want 1/00000099", a_bsa, a_rda);
        end
        wback(5'd9, 32'h9A);
        idle(); rd_addr_a = 5'd9;
        #1;
        checks++;
        if (a_bsa !== 1'b0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL simul_drain got busy=%b err=%b want 0/0", a_bsa, a_err);
        end
        wback(5'd10, 32'hCAFE0010);
        idle(); rd_addr_b = 5'd10;
        #1;
        checks++;
        if (a_err !== 1'b1 || a_rdb !== 32'hCAFE0010 || a_bsb !== 1'b0) begin
            failures++;
            $display("FAIL underflow got err=%b data=%h busy=%b want 1/cafe0010/0",
                     a_err, a_rdb, a_bsb);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(5'd4); issue(5'd4);
        wback(5'd4, 32'h55);
        idle();
        reset = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
        cyc();
        idle(); rd_addr_a = 5'd4;
        #1;
        checks++;
        if (a_rda !== 32'h0 || a_bsa !== 1'b0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got data=%h busy=%b err=%b want 0/0/0",
                     a_rda, a_bsa, a_err);
        end
        wback(5'd4, 32'h44);
        #1;
        checks++;
        if (a_err !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard got err=%b want 1", a_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            reset     = ($urandom_range(0, 59) == 0);
            iss_en    = $urandom_range(0, 1);
            wr_en     = $urandom_range(0, 2) == 0;
            iss_addr  = 5'($urandom_range(0, 7));
            wr_addr   = 5'($urandom_range(0, 7));
            rd_addr_a = 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            if (iss_en && wr_en && iss_addr == wr_addr && m_cnt[wr_addr] == 0)
                wr_en = 1'b0;
            #1;
            checks++;
            if (a_rda !== exp_rd(rd_addr_a, 1) || a_rdb !== exp_rd(rd_addr_b, 1) ||
                b_rda !== exp_rd(rd_addr_a, 0) || b_rdb !== exp_rd(rd_addr_b, 0)) begin
                failures++;
                $display("FAIL rnd_data n=%0d got %h %h %h %h want %h %h %h %h", n,
                         a_rda, a_rdb, b_rda, b_rdb,
                         exp_rd(rd_addr_a, 1), exp_rd(rd_addr_b, 1),
                         exp_rd(rd_addr_a, 0), exp_rd(rd_addr_b, 0));
            end
            checks++;
            if (a_bsa !== exp_busy(rd_addr_a, 1) || a_bsb !== exp_busy(rd_addr_b, 1) ||
                b_bsa !== exp_busy(rd_addr_a, 0) || b_bsb !== exp_busy(rd_addr_b, 0)) begin
                failures++;
                $display("FAIL rnd_busy n=%0d got %b%b%b%b want %b%b%b%b", n,
                         a_bsa, a_bsb, b_bsa, b_bsb,
                         exp_busy(rd_addr_a, 1), exp_busy(rd_addr_b, 1),
                         exp_busy(rd_addr_a, 0), exp_busy(rd_addr_b, 0));
            end
            checks++;
            if (a_full !== exp_full() || b_full !== exp_full() ||
                a_err !== m_err || b_err !== m_err) begin
                failures++;
                $display("FAIL rnd_flags n=%0d got full=%b%b err=%b%b want full=%b err=%b",
                         n, a_full, b_full, a_err, b_err, exp_full(), m_err);
            end
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'h0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_full();
        test_simul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_regfile.md
SB_REGFILE -- requirements
Module: sb_regfile

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 SHALL provide parameter CNT_W, default 2, width of each per-register in-flight write counter.
REQ-004 SHALL provide parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL use clk, input, 1 bit, as the clock; all state updates on its rising edge.
REQ-007 SHALL use reset, input, 1 bit, as a synchronous, active-high reset.
REQ-008 SHALL provide rd_addr_a and rd_addr_b, inputs, ADDR_W bits each, read addresses.
REQ-009 SHALL provide rd_data_a and rd_data_b, outputs, DATA_W bits each, combinational read data.
REQ-010 SHALL provide rd_busy_a and rd_busy_b, outputs, 1 bit each; 1 = addressed register has a pending producer.
REQ-011 SHALL provide iss_en, input, 1 bit, and iss_addr, input, ADDR_W bits; together they announce a future write to iss_addr.
REQ-012 SHALL provide iss_full, output, 1 bit; 1 = the issue presented this cycle is refused.
REQ-013 SHALL provide wr_en, input, 1 bit; wr_addr, input, ADDR_W bits; wr_data, input, DATA_W bits; these form the writeback port.
REQ-014 SHALL provide err_underflow, output, 1 bit, a sticky flag for writeback with no pending issue.

Function
REQ-015 SHALL update reg[wr_addr] <= wr_data at the clock edge when wr_en=1, except when wr_addr=0 and ZERO_REG=1.
REQ-016 SHALL make rd_data_x = reg[rd_addr_x] combinationally; when ZERO_REG=1 and rd_addr_x=0, SHALL return 0.
REQ-017 With BYPASS=1, wr_en=1, and wr_addr=rd_addr_x (and not a hardwired register 0), SHALL return wr_data on rd_data_x in the same cycle.
REQ-018 With BYPASS=0, SHALL return the old value on a same-cycle read; the new value is visible from the next cycle.
REQ-019 SHALL keep one counter cnt[r] of CNT_W bits per register r, counting issued but not yet written-back writes.
REQ-020 SHALL accept an issue when iss_en=1 and cnt[iss_addr] < 2**CNT_W-1; an accepted issue alone increments cnt[iss_addr].
REQ-021 SHALL drive iss_full=1 combinationally when iss_en=1 and cnt[iss_addr] is at its maximum; the refused issue SHALL leave the counter unchanged, and the issuer must hold and retry.
REQ-022 SHALL decrement cnt[wr_addr] on wr_en=1 alone when cnt[wr_addr] > 0.
REQ-023 On an accepted issue and a writeback to the same register in the same cycle, cnt SHALL remain unchanged.
REQ-024 On a writeback to a register with cnt=0, SHALL still write the data, keep cnt at 0, and set err_underflow=1 from the next cycle.
REQ-025 When ZERO_REG=1, SHALL ignore issues and writebacks to address 0 for counting; iss_full SHALL be 0 for address 0, and these SHALL never set err_underflow.
REQ-026 SHALL drive rd_busy_x = (cnt[rd_addr_x] != 0), except it SHALL be 0 when BYPASS=1, wr_en=1, wr_addr=rd_addr_x, and cnt=1.
REQ-027 rd_busy_x SHALL ignore a same-cycle issue; the issuing instruction is younger than the reader.
REQ-028 rd_busy_x SHALL be 0 for register 0 when ZERO_REG=1.

Reset
REQ-029 When reset=1 at a clock edge, SHALL clear all registers, all cnt[], and err_underflow to 0, overriding simultaneous iss_en and wr_en.
REQ-030 During and after reset, with all addresses at 0, SHALL drive rd_data_x=0, rd_busy_x=0, and iss_full=0.
REQ-031 Reset asserted mid-operation SHALL discard all pending issues; subsequent writebacks to the previously pending registers set err_underflow.

Verification
REQ-032 Bench SHALL cover: write r5=0x12345678, then read rd_addr_a=5 next cycle -> rd_data_a=0x12345678 and rd_busy_a=0.
REQ-033 Bench SHALL cover: wr_en to r0 with 0xFFFFFFFF, then read r0 -> 0; iss_en to r0 -> iss_full=0 and rd_busy=0.
REQ-034 Bench SHALL cover: issue r7, read r7 -> busy=1; writeback r7=0xA5A5A5A5 with a same-cycle read -> rd_data=0xA5A5A5A5 and busy=0 (BYPASS=1); with BYPASS=0 -> old value is returned.
REQ-035 Bench SHALL cover: issue r3 three times (CNT_W=2) -> cnt=3; a fourth issue -> iss_full=1 and cnt stays 3; three writebacks -> busy clears only after the third.
REQ-036 Bench SHALL cover: simultaneous issue and writeback to r9 with cnt=1 -> cnt stays 1 and busy stays 1; writeback r10 with cnt=0 -> data written and err_underflow=1 next cycle.
REQ-037 Bench SHALL cover: with r4 pending and r4=0x55 stored, assert reset -> next cycle r4 reads 0, busy=0, and err_underflow=0.
